// File: rtl/i2c_slave_pkg.sv
// -----------------------------------------------------------------------------
// i2c_slave_pkg
// Shared types and constants for the I2C slave bus engine:
//   - i2c_state_t : protocol FSM states
//   - I2C_ACK / I2C_NACK : SDA level in the acknowledge slot
//   - RW_WRITE / RW_READ : R/W bit of the address byte
// -----------------------------------------------------------------------------
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_LOAD,
        RD_DATA,
        RD_MACK,
        IGNORE
    } i2c_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// -----------------------------------------------------------------------------
// i2c_line_sync
// Synchronises the raw SCL/SDA pins into the clk domain and detects bus events.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   scl_in, sda_in    raw pins
//   sda               synchronised SDA level (used for bit sampling)
//   scl_rise/scl_fall one-clk pulses on synchronised SCL edges
//   start/stop        one-clk pulses for START (SDA fall, SCL high) and
//                     STOP (SDA rise, SCL high)
// Event latency from pin to pulse is SYNC_STAGES+1 clk. SYNC_STAGES >= 2.
// -----------------------------------------------------------------------------
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_s;
    logic                   sda_s;

    // Reset to the idle-bus level (both lines high) so no phantom edge
    // appears when reset is released on a quiet bus.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign sda      = sda_s;
    assign scl_rise =  scl_s & ~scl_prev;
    assign scl_fall = ~scl_s &  scl_prev;
    // SCL must be high on both sides of the SDA transition.
    assign start    = scl_s & scl_prev &  sda_prev & ~sda_s;
    assign stop     = scl_s & scl_prev & ~sda_prev &  sda_s;

endmodule

// File: rtl/i2c_slave_bus_engine.sv
// -----------------------------------------------------------------------------
// i2c_slave_bus_engine
// I2C slave protocol engine between the SCL/SDA pins and the slave RAM
// controller. Decodes START/STOP and the address byte; on a master write it
// pushes bytes to master RAM, on a master read it fetches bytes from slave RAM
// and shifts them onto SDA. No clock stretching.
// Ports:
//   clk, reset        system clock (>= 16x SCL), synchronous active-high reset
//   slaveAddr         own 7-bit address, compared when the address byte ends
//   scl_in, sda_in    raw pins
//   sda_oe            1 = pull SDA low, 0 = release
//   masterRAM_WADD/DIN/W  write port (W is a one-clk strobe)
//   slaveRAM_RADD     read address; slaveRAM_DOUT returns 1 clk later
//   busy              high while addressed, until STOP / NACK / mismatch
// -----------------------------------------------------------------------------
module i2c_slave_bus_engine
    import i2c_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        slaveAddr,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [ADDR_W-1:0] masterRAM_WADD,
    output logic [7:0]        masterRAM_DIN,
    output logic              masterRAM_W,
    output logic [ADDR_W-1:0] slaveRAM_RADD,
    input  logic [7:0]        slaveRAM_DOUT,
    output logic              busy
);

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    i2c_state_t        state,     state_n;
    logic [3:0]        bit_cnt,   bit_cnt_n;    // bits shifted in/out this byte
    logic [7:0]        shift,     shift_n;      // receive shift register
    logic [7:0]        rd_shift,  rd_shift_n;   // transmit shift register
    logic              rw,        rw_n;
    logic              ack_phase, ack_phase_n;  // 0: ACK not yet driven, 1: driving
    logic [1:0]        fetch_cnt, fetch_cnt_n;  // clks since RADD was updated
    logic [ADDR_W-1:0] ptr,       ptr_n;
    logic              sda_oe_n;
    logic [ADDR_W-1:0] wadd_n;
    logic [7:0]        din_n;
    logic              w_n;
    logic [ADDR_W-1:0] radd_n;
    logic              busy_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shift          <= '0;
            rd_shift       <= '0;
            rw             <= RW_WRITE;
            ack_phase      <= 1'b0;
            fetch_cnt      <= '0;
            ptr            <= '0;
            sda_oe         <= 1'b0;
            masterRAM_WADD <= '0;
            masterRAM_DIN  <= '0;
            masterRAM_W    <= 1'b0;
            slaveRAM_RADD  <= '0;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            bit_cnt        <= bit_cnt_n;
            shift          <= shift_n;
            rd_shift       <= rd_shift_n;
            rw             <= rw_n;
            ack_phase      <= ack_phase_n;
            fetch_cnt      <= fetch_cnt_n;
            ptr            <= ptr_n;
            sda_oe         <= sda_oe_n;
            masterRAM_WADD <= wadd_n;
            masterRAM_DIN  <= din_n;
            masterRAM_W    <= w_n;
            slaveRAM_RADD  <= radd_n;
            busy           <= busy_n;
        end
    end

    // NOTE: every signal written here is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        rd_shift_n  = rd_shift;
        rw_n        = rw;
        ack_phase_n = ack_phase;
        fetch_cnt_n = fetch_cnt;
        ptr_n       = ptr;
        sda_oe_n    = sda_oe;
        wadd_n      = masterRAM_WADD;
        din_n       = masterRAM_DIN;
        w_n         = 1'b0;
        radd_n      = slaveRAM_RADD;
        busy_n      = busy;

        // Bus conditions override any bit activity in the same clk; a
        // partially received byte is simply dropped.
        if (stop) begin
            state_n     = IDLE;
            sda_oe_n    = 1'b0;
            busy_n      = 1'b0;
            ack_phase_n = 1'b0;
        end else if (start) begin
            state_n     = ADDR;
            bit_cnt_n   = '0;
            ptr_n       = '0;
            ack_phase_n = 1'b0;
            sda_oe_n    = 1'b0;
        end else begin
            case (state)
                IDLE: ;

                ADDR: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda};
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (shift[6:0] == slaveAddr) begin
                                state_n     = ADDR_ACK;
                                rw_n        = sda;
                                busy_n      = 1'b1;
                                ack_phase_n = 1'b0;
                                // Start the first read fetch now so the byte
                                // is ready well before the ACK slot ends.
                                radd_n      = ptr;
                                fetch_cnt_n = '0;
                            end else begin
                                state_n = IGNORE;
                                busy_n  = 1'b0;
                            end
                        end
                    end
                end

                ADDR_ACK: begin
                    if (fetch_cnt != 2'd2) begin
                        fetch_cnt_n = fetch_cnt + 2'd1;
                        if (fetch_cnt == 2'd1) rd_shift_n = slaveRAM_DOUT;
                    end
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe_n    = ~I2C_ACK;
                            ack_phase_n = 1'b1;
                        end else begin
                            ack_phase_n = 1'b0;
                            if (rw == RW_WRITE) begin
                                sda_oe_n  = 1'b0;
                                bit_cnt_n = '0;
                                state_n   = WR_DATA;
                            end else begin
                                // The fall that ends the ACK also launches
                                // the MSB of the first read byte.
                                sda_oe_n   = ~rd_shift_n[7];
                                rd_shift_n = {rd_shift_n[6:0], 1'b0};
                                bit_cnt_n  = 4'd1;
                                state_n    = RD_DATA;
                            end
                        end
                    end
                end

                WR_DATA: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda};
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state_n     = WR_ACK;
                            ack_phase_n = 1'b0;
                        end
                    end
                end

                WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe_n    = ~I2C_ACK;
                            wadd_n      = ptr;
                            din_n       = shift;
                            w_n         = 1'b1;
                            ack_phase_n = 1'b1;
                        end else begin
                            sda_oe_n    = 1'b0;
                            ptr_n       = ptr + ADDR_W'(1);
                            ack_phase_n = 1'b0;
                            bit_cnt_n   = '0;
                            state_n     = WR_DATA;
                        end
                    end
                end

                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_n = 1'b0;
                            state_n  = RD_MACK;
                        end else begin
                            sda_oe_n   = ~rd_shift[7];
                            rd_shift_n = {rd_shift[6:0], 1'b0};
                            bit_cnt_n  = bit_cnt + 4'd1;
                        end
                    end
                end

                RD_MACK: begin
                    if (scl_rise) begin
                        if (sda == I2C_ACK) begin
                            ptr_n       = ptr + ADDR_W'(1);
                            radd_n      = ptr + ADDR_W'(1);
                            fetch_cnt_n = '0;
                            state_n     = RD_LOAD;
                        end else if (sda == I2C_NACK) begin
                            busy_n  = 1'b0;
                            state_n = IGNORE;
                        end
                    end
                end

                RD_LOAD: begin
                    // RADD was set on entry; RAM registers it on the next
                    // edge, so DOUT is captured on the second edge.
                    fetch_cnt_n = fetch_cnt + 2'd1;
                    if (fetch_cnt == 2'd1) begin
                        rd_shift_n = slaveRAM_DOUT;
                        bit_cnt_n  = '0;
                        state_n    = RD_DATA;
                    end
                end

                IGNORE: sda_oe_n = 1'b0;

                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_bus_engine.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_bus_engine
// Directed bench: an I2C master model drives SCL/SDA (open-drain wired with
// sda_oe), a registered 1-clk slave RAM model answers reads, and master RAM
// writes are collected into queues. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_i2c_slave_bus_engine;
    import i2c_slave_pkg::*;

    localparam int ADDR_W = 5;
    localparam int Q      = 5;   // clks per quarter SCL period (SCL = clk/20)

    logic              clk = 1'b0;
    logic              reset;
    logic [6:0]        slaveAddr;
    logic              scl_m;
    logic              sda_m;
    logic              sda_line;
    logic              sda_oe;
    logic [ADDR_W-1:0] masterRAM_WADD;
    logic [7:0]        masterRAM_DIN;
    logic              masterRAM_W;
    logic [ADDR_W-1:0] slaveRAM_RADD;
    logic [7:0]        slaveRAM_DOUT;
    logic              busy;

    logic [7:0]        mem [32];
    logic [ADDR_W-1:0] wq_addr [$];
    logic [7:0]        wq_data [$];
    logic              oe_seen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_bus_engine #(.SYNC_STAGES(2), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .slaveAddr      (slaveAddr),
        .scl_in         (scl_m),
        .sda_in         (sda_line),
        .sda_oe         (sda_oe),
        .masterRAM_WADD (masterRAM_WADD),
        .masterRAM_DIN  (masterRAM_DIN),
        .masterRAM_W    (masterRAM_W),
        .slaveRAM_RADD  (slaveRAM_RADD),
        .slaveRAM_DOUT  (slaveRAM_DOUT),
        .busy           (busy)
    );

    always @(posedge clk) slaveRAM_DOUT <= mem[slaveRAM_RADD];

    always @(posedge clk) begin
        if (masterRAM_W === 1'b1) begin
            wq_addr.push_back(masterRAM_WADD);
            wq_data.push_back(masterRAM_DIN);
        end
        if (sda_oe === 1'b1) oe_seen <= 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        ack = sda_line;
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] data);
        data = '0;
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1; wait_q();
            scl_m = 1'b1; wait_q();
            data = {data[6:0], sda_line};
            wait_q();
            scl_m = 1'b0; wait_q();
        end
        send_bit(mack);
        sda_m = 1'b1;
    endtask

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        oe_seen = 1'b0;
    endtask

    initial begin
        logic       ack;
        logic       any_nack;
        logic [7:0] rd;

        reset     = 1'b1;
        slaveAddr = 7'h42;
        scl_m     = 1'b1;
        sda_m     = 1'b1;
        oe_seen   = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[0] = 8'hA5;
        mem[1] = 8'h3C;
        repeat (4) @(posedge clk);
        #1;

        // Reset state
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_w",      32'(masterRAM_W), 0);
        check("rst_wadd",   32'(masterRAM_WADD), 0);
        check("rst_din",    32'(masterRAM_DIN), 0);
        check("rst_radd",   32'(slaveRAM_RADD), 0);
        check("rst_busy",   32'(busy), 0);
        reset = 1'b0;
        wait_q();

        // Write two bytes to own address
        clear_log();
        i2c_start();
        write_byte(8'h84, ack); check("wr_addr_ack", 32'(ack), 0);
        check("wr_busy_mid", 32'(busy), 1);
        write_byte(8'h41, ack); check("wr_b1_ack", 32'(ack), 0);
        write_byte(8'h42, ack); check("wr_b2_ack", 32'(ack), 0);
        i2c_stop();
        check("wr_count",  wq_addr.size(), 2);
        if (wq_addr.size() == 2) begin
            check("wr0_addr", 32'(wq_addr[0]), 0);
            check("wr0_data", 32'(wq_data[0]), 32'h41);
            check("wr1_addr", 32'(wq_addr[1]), 1);
            check("wr1_data", 32'(wq_data[1]), 32'h42);
        end
        check("wr_busy_after_stop", 32'(busy), 0);

        // Address mismatch: 0x86 -> 0x43
        clear_log();
        i2c_start();
        write_byte(8'h86, ack); check("mm_no_ack", 32'(ack), 1);
        write_byte(8'h55, ack);
        check("mm_oe_never", 32'(oe_seen), 0);
        check("mm_busy", 32'(busy), 0);
        i2c_stop();
        check("mm_no_writes", wq_addr.size(), 0);

        // Read two bytes: ACK the first, NACK the second
        i2c_start();
        write_byte(8'h85, ack); check("rd_addr_ack", 32'(ack), 0);
        read_byte(1'b0, rd); check("rd_b0", 32'(rd), 32'hA5);
        read_byte(1'b1, rd); check("rd_b1", 32'(rd), 32'h3C);
        wait_q();
        check("rd_release_after_nack", 32'(sda_oe), 0);
        check("rd_busy_after_nack", 32'(busy), 0);
        i2c_stop();

        // 33-byte write, pointer wraps to 0
        clear_log();
        any_nack = 1'b0;
        i2c_start();
        write_byte(8'h84, ack); any_nack |= ack;
        for (int i = 0; i < 33; i++) begin
            write_byte(8'h10 + 8'(i), ack);
            any_nack |= ack;
        end
        i2c_stop();
        check("wrap_all_acked", 32'(any_nack), 0);
        check("wrap_count", wq_addr.size(), 33);
        if (wq_addr.size() == 33) begin
            check("wrap_first_data", 32'(wq_data[0]), 32'h10);
            check("wrap_addr31", 32'(wq_addr[31]), 31);
            check("wrap_addr32", 32'(wq_addr[32]), 0);
            check("wrap_data32", 32'(wq_data[32]), 32'h30);
        end

        // STOP after 4 data bits: no write
        clear_log();
        i2c_start();
        write_byte(8'h84, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        wait_q();
        check("abort_no_write", wq_addr.size(), 0);
        check("abort_busy", 32'(busy), 0);

        // Reset while the slave is driving a read bit (0xA5: bit6 = 0)
        i2c_start();
        write_byte(8'h85, ack);
        sda_m = 1'b1; wait_q(); scl_m = 1'b1; wait_q(); wait_q(); scl_m = 1'b0; wait_q();
        sda_m = 1'b1; wait_q(); scl_m = 1'b1; wait_q();
        check("rst_mid_driving", 32'(sda_oe), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_oe", 32'(sda_oe), 0);
        check("rst_mid_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;
        wait_q(); scl_m = 1'b0; wait_q();
        send_bit(1'b0); send_bit(1'b1);
        check("rst_mid_ignored", 32'(oe_seen & (sda_oe | busy)), 0);
        i2c_stop();

        // Write one byte, repeated START, read restarts at address 0
        clear_log();
        i2c_start();
        write_byte(8'h84, ack);
        write_byte(8'h77, ack); check("rs_wr_ack", 32'(ack), 0);
        i2c_start();
        write_byte(8'h85, ack); check("rs_rd_addr_ack", 32'(ack), 0);
        read_byte(1'b1, rd);    check("rs_rd_data", 32'(rd), 32'hA5);
        i2c_stop();
        check("rs_write_count", wq_addr.size(), 1);
        if (wq_addr.size() == 1) begin
            check("rs_write_addr", 32'(wq_addr[0]), 0);
            check("rs_write_data", 32'(wq_data[0]), 32'h77);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_bus_engine.md
# i2c_slave_bus_engine

I2C slave protocol engine that sits between the board's SCL/SDA pins and the slave RAM controller. It decodes START/STOP and the address byte, then acts on the transfer direction. On a master write it pushes received bytes into master RAM through the controller's master-write port. On a master read it fetches bytes from slave RAM through the controller's slave-read port and shifts them onto SDA. No clock stretching; SCL is input-only.

## Interface
- SYNC_STAGES, 2: synchronizer flops on scl_in/sda_in.
- ADDR_W, 5: RAM address width (32 bytes).
- clk  in  1  system clock, ≥ 16× SCL frequency.
- reset  in  1  synchronous, active-high.
- slaveAddr  in  7  own 7-bit I2C address, sampled when the address byte completes.
- scl_in  in  1  raw SCL pin.
- sda_in  in  1  raw SDA pin.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- masterRAM_WADD  out  ADDR_W  write address to master RAM.
- masterRAM_DIN  out  8  received byte.
- masterRAM_W  out  1  one-clk write strobe.
- slaveRAM_RADD  out  ADDR_W  read address into slave RAM.
- slaveRAM_DOUT  in  8  slave RAM data, registered, 1-clk latency.
- busy  out  1  high from an addressed START until STOP/NACK/mismatch.

## Operation
- Line conditioning:
  - SYNC_STAGES flops, then a previous-value register.
  - Edge definitions: scl_rise, scl_fall; START = sda high→low while scl high; STOP = sda low→high while scl high.
- Data bits are sampled on scl_rise. sda_oe changes only on scl_fall.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_MACK, IGNORE.
- IDLE/any state + START → ADDR. Bit counter and byte pointer (ptr) clear to 0. This includes repeated START.
- ADDR: shift 8 bits MSB first. After the 8th bit, compare [7:1] with slaveAddr:
  - match → ADDR_ACK;
  - mismatch → IGNORE, no ACK.
- ADDR_ACK:
  - next scl_fall → sda_oe=1.
  - Following scl_fall → release sda_oe; go to WR_DATA if R/W=0, RD_DATA if R/W=1.
  - For a read, slaveRAM_RADD=ptr is set on entry and the byte is captured 2 clk later. The first data bit is driven on the scl_fall that ends the ACK.
- WR_DATA: shift 8 bits → WR_ACK.
- WR_ACK:
  - On scl_fall: sda_oe=1; masterRAM_WADD=ptr, masterRAM_DIN=byte, masterRAM_W=1 for exactly one clk.
  - On the next scl_fall: release sda_oe, ptr=ptr+1, return to WR_DATA.
- RD_DATA: on each scl_fall drive sda_oe=~bit (MSB first). After the 8th bit's scl_fall completes, release SDA → RD_MACK.
- RD_MACK: sample SDA on scl_rise.
  - low (ACK) → ptr+1, RD_LOAD.
  - high (NACK) → IGNORE.
- RD_LOAD: slaveRAM_RADD=ptr, capture DOUT 2 clk later → RD_DATA.
- IGNORE: sda_oe=0. Wait for START → ADDR, or STOP → IDLE.
- STOP in any state → IDLE, sda_oe=0, busy=0. A byte received without its 8th bit is discarded; no write is issued.
- ptr is ADDR_W bits and wraps 31→0 silently on both read and write.

## Timing
- Reset values: sda_oe=0, masterRAM_W=0, masterRAM_WADD=0, masterRAM_DIN=0, slaveRAM_RADD=0, busy=0, state=IDLE, ptr=0.
- Reset asserted mid-transfer: SDA released on the next clk. The bus is ignored until the next START.
- Pin-to-event latency: SYNC_STAGES+1 clk.
- masterRAM_W: one pulse per fully received, ACKed data byte. WADD and DIN are stable in the same cycle as the pulse.
- Read fetch: RADD valid ≥2 clk before the capturing edge, which suits the controller's 1-clk registered read.
- START and STOP take priority over a bit sample in the same clk.

## Structure
- Package i2c_slave_pkg:
  - state enum;
  - I2C_ACK=1'b0, I2C_NACK=1'b1;
  - RW_WRITE=1'b0, RW_READ=1'b1.
- Sub-module i2c_line_sync: synchronizers plus scl_rise/scl_fall/start/stop detection.

## Test plan
- slaveAddr=7'h42. START, 0x84, 0x41, 0x42, STOP:
  - ACK on all three bytes;
  - masterRAM_W pulses twice: (0,0x41), (1,0x42);
  - busy drops after STOP.
- slaveAddr=7'h42, address byte 0x86 → no ACK (sda_oe stays 0), no writes, busy=0.
- Slave RAM preloaded [0]=0xA5, [1]=0x3C. START, 0x85, master ACKs byte 1, NACKs byte 2:
  - SDA carries 0xA5 then 0x3C;
  - slave releases SDA after the NACK.
- 33-byte write from ptr 0: the 33rd byte is written to address 0 (wrap).
- Abort cases:
  - STOP after 4 data bits → no write pulse;
  - reset asserted during a read bit → sda_oe=0 the next clk, state IDLE.
- Write 1 byte, then repeated START + 0x85: read restarts at address 0.
